// File: rtl/mem_responder_if.sv
// Bus bundle between a core-side requester and mem_responder.
//   master modport : requester (drives fetch PC, load and store requests)
//   slave modport  : mem_responder (returns instruction, load data, stall, occupancy)
// Signals:
//   pc       - instruction fetch byte address      inst     - fetched instruction word
//   load_en  - load request this cycle             l_addr   - load byte address
//   l_data   - load data (0 when no load)          store_en - store request this cycle
//   s_addr   - store byte address                  s_data   - store data
//   stall    - store refused, hold and retry       sb_count - store-buffer occupancy
// Handshake: a store is taken at the rising edge of any cycle where store_en=1 and
// stall=0; while stall=1 the requester keeps store_en/s_addr/s_data unchanged.
// Loads have no handshake: l_data is valid combinationally in the cycle load_en=1.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface mem_responder_if #(
    parameter int W        = `WORD_WIDTH,
    parameter int SB_DEPTH = 4
);
    localparam int CW = $clog2(SB_DEPTH) + 1;

    logic [W-1:0]  pc;
    logic [W-1:0]  inst;
    logic          load_en;
    logic [W-1:0]  l_addr;
    logic [W-1:0]  l_data;
    logic          store_en;
    logic [W-1:0]  s_addr;
    logic [W-1:0]  s_data;
    logic          stall;
    logic [CW-1:0] sb_count;

    modport master (
        output pc, load_en, l_addr, store_en, s_addr, s_data,
        input  inst, l_data, stall, sb_count
    );

    modport slave (
        input  pc, load_en, l_addr, store_en, s_addr, s_data,
        output inst, l_data, stall, sb_count
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: instruction ROM plus single-ported data RAM fronted by a
// store buffer. Stores are queued and drained to dmem in cycles without a
// load, so loads always own the RAM port. Loads forward from the youngest
// matching buffered store.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (clears the store buffer only)
//   bus  - mem_responder_if.slave (fetch, load, store, stall, sb_count)
// Word index of every address is addr[AW+1:2]; other bits are ignored.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mem_responder #(
    parameter int W        = `WORD_WIDTH,
    parameter int AW       = 10,
    parameter int SB_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    localparam int            PW    = $clog2(SB_DEPTH);
    localparam int            CW    = PW + 1;
    localparam int            DEPTH = 1 << AW;
    localparam logic [CW-1:0] FULL  = CW'(SB_DEPTH);

    // imem is a read-only program image loaded from outside this block.
    logic [W-1:0] imem [DEPTH];
    logic [W-1:0] dmem [DEPTH];

    logic [AW-1:0] pc_idx;
    logic [AW-1:0] l_idx;
    logic [AW-1:0] s_idx;

    assign pc_idx = bus.pc[AW+1:2];
    assign l_idx  = bus.l_addr[AW+1:2];
    assign s_idx  = bus.s_addr[AW+1:2];

    // Byte-offset and high address bits are deliberately dropped (word wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.pc[W-1:AW+2], bus.pc[1:0],
                                bus.l_addr[W-1:AW+2], bus.l_addr[1:0],
                                bus.s_addr[W-1:AW+2], bus.s_addr[1:0]};

    // Store buffer state
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic [SB_DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]       addr_q [SB_DEPTH];
    logic [AW-1:0]       addr_d [SB_DEPTH];
    logic [W-1:0]        data_q [SB_DEPTH];
    logic [W-1:0]        data_d [SB_DEPTH];

    logic          full;
    logic          drain;
    logic          accept;
    logic          fwd_hit;
    logic [W-1:0]  fwd_data;
    logic [PW-1:0] slot;

    // A drain frees the head slot at the same edge, so a full buffer can still
    // take a store in a cycle without a load.
    always_comb begin
        full   = (count_q == FULL);
        drain  = (count_q != '0) && !bus.load_en && !rst;
        accept = bus.store_en && !rst && (!full || drain);
    end

    // Scan oldest to youngest from head; the last hit is the youngest match.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            slot = head_q + PW'(k);
            if (valid_q[slot] && (addr_q[slot] == l_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[slot];
            end
        end
    end

    always_comb begin
        bus.inst     = imem[pc_idx];
        bus.l_data   = '0;
        if (bus.load_en) begin
            bus.l_data = fwd_hit ? fwd_data : dmem[l_idx];
        end
        bus.stall    = bus.store_en && full && bus.load_en && !rst;
        bus.sb_count = count_q;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        // Drain before accept: when full, head==tail and the slot is reused.
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (accept) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = s_idx;
            data_d[tail_q]  = bus.s_data;
            tail_d          = tail_q + PW'(1);
        end
        case ({accept, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
        // Payload needs no reset: valid bits gate every use.
        addr_q <= addr_d;
        data_q <= data_d;
    end

    always_ff @(posedge clk) begin
        if (drain) begin
            dmem[addr_q[head_q]] <= data_q[head_q];
        end
    end
endmodule
